reg_file_arbiter: RTL and testbench

//  Shares the single read/write port of the 8x8 register file between two requesters:
//  req 0 = core datapath, req 1 = loader/debug port. Round-robin arbitration with an

---
 rtl/reg_arb_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 31 +++
 rtl/reg_file_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_reg_file_arbiter.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// ----------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and constants for the register-file port arbiter.
//   NUM_REQ   : number of requesters sharing the register-file port
//   DW / AW   : data and address widths of the register file
//   NUM_REGS  : implemented registers; addresses at or above this are errors
//   state_t   : arbiter FSM states
// ----------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int NUM_REQ  = 2;
    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int NUM_REGS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req    in  [1:0]  request lines
//   last   in  1      requester that was granted most recently
//   valid  out 1      at least one request is present
//   winner out 1      index of the chosen requester (only meaningful with valid)
// ----------------------------------------------------------------------------
module rr_pick2
    import reg_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               valid,
    output logic               winner
);

    // A lone requester always wins. When both ask, the one that was not
    // served last time gets the port, which gives strict alternation under
    // sustained contention.
    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// ----------------------------------------------------------------------------
// reg_file_arbiter
// Shares the single read/write port of the 8x8 register file between the
// core datapath (requester 0) and the loader/debug port (requester 1).
// Round-robin between requesters, with a per-requester lock that keeps the
// port for back-to-back accesses. This block is the only driver of the
// register file's write enable, addresses and write data.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req/we/lock [1:0]     per-requester request, write flag and lock
//   addr0/addr1           per-requester register address
//   wdata0/wdata1         per-requester write data
//   gnt [1:0]             one-cycle pulse: request consumed
//   rvalid [1:0]          one-cycle pulse: rdata valid for that requester
//   rdata                 read response data
//   err [1:0]             pulses with gnt when the address is out of range
//   rf_wr_en              register file write enable
//   rf_rdwr_addr          register file read/write address
//   rf_rd_addr            register file read address (same as rf_rdwr_addr)
//   rf_dat_in             register file write data
//   rf_datA_out           register file read data
// ----------------------------------------------------------------------------
module reg_file_arbiter
    import reg_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] we,
    input  logic [AW-1:0]      addr0,
    input  logic [AW-1:0]      addr1,
    input  logic [DW-1:0]      wdata0,
    input  logic [DW-1:0]      wdata1,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rvalid,
    output logic [DW-1:0]      rdata,
    output logic [NUM_REQ-1:0] err,
    output logic               rf_wr_en,
    output logic [AW-1:0]      rf_rdwr_addr,
    output logic [AW-1:0]      rf_rd_addr,
    output logic [DW-1:0]      rf_dat_in,
    input  logic [DW-1:0]      rf_datA_out
);

    localparam logic [AW:0] NumRegsW = (AW+1)'(NUM_REGS);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            last_q, last_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            pickValid;
    logic            pickWinner;
    logic            latchNew;
    logic            latchOwner;
    logic            lockGo;
    logic            addrOk;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pickValid),
        .winner (pickWinner)
    );

    assign addrOk = ({1'b0, addr_q} < NumRegsW);
    assign lockGo = lock[owner_q] & req[owner_q];

    // State register. Reset parks the FSM in IDLE; last starts at 1 so that
    // requester 0 wins the very first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request, round-robin history and read-data holding register.
    // rdata only changes at read capture or reset, so it stays stable for
    // the requester long after its rvalid pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic. A new request is latched either from IDLE via the
    // round-robin picker, or directly from the current owner when it holds
    // its lock as its access completes (write leaving ACCESS, read leaving
    // RESP). The lock path ignores the other requester entirely.
    always_comb begin
        state_d    = state_q;
        latchNew   = 1'b0;
        latchOwner = owner_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d    = ACCESS;
                    latchNew   = 1'b1;
                    latchOwner = pickWinner;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    state_d = RESP;
                end else if (lockGo) begin
                    state_d  = ACCESS;
                    latchNew = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (lockGo) begin
                    state_d  = ACCESS;
                    latchNew = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values. The winning requester's command is captured when
    // latchNew fires. ACCESS is where the owner is recorded as last served
    // and where read data is sampled from the register file; an out-of-range
    // read returns zero instead of whatever the register file presents.
    always_comb begin
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        if (latchNew) begin
            owner_d = latchOwner;
            we_d    = we[latchOwner];
            addr_d  = latchOwner ? addr1 : addr0;
            wdata_d = latchOwner ? wdata1 : wdata0;
        end
        if (state_q == ACCESS) begin
            last_d = owner_q;
            if (!we_q) begin
                rdata_d = addrOk ? rf_datA_out : '0;
            end
        end
    end

    // Output decode. gnt and err pulse during ACCESS, rvalid during RESP.
    // The write enable is suppressed for an out-of-range address so the
    // register file never sees an illegal write.
    always_comb begin
        gnt      = '0;
        err      = '0;
        rvalid   = '0;
        rf_wr_en = 1'b0;
        case (state_q)
            ACCESS: begin
                gnt[owner_q] = 1'b1;
                err[owner_q] = ~addrOk;
                rf_wr_en     = we_q & addrOk;
            end
            RESP: begin
                rvalid[owner_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Register file addresses and data simply follow the latched command, so
    // they keep the last latched values while the arbiter is idle.
    assign rdata        = rdata_q;
    assign rf_rdwr_addr = addr_q;
    assign rf_rd_addr   = addr_q;
    assign rf_dat_in    = wdata_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_file_arbiter
// Bench for reg_file_arbiter with a behavioural 8x8 register file attached.
// Each scenario task drives its own stimulus and checks results against a
// transaction-level model (memory array, last-served requester, lock rule).
// ----------------------------------------------------------------------------
module tb_reg_file_arbiter;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       lk;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [1:0] we;
    logic [3:0] addr0;
    logic [3:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] lock;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata;
    logic [1:0] err;
    logic       rf_wr_en;
    logic [3:0] rf_rdwr_addr;
    logic [3:0] rf_rd_addr;
    logic [7:0] rf_dat_in;
    logic [7:0] rf_datA_out;

    int checks = 0;
    int failures = 0;

    logic [7:0] modelMem [8];
    logic       lastModel;

    logic [7:0] rfMem [8] = '{default: 8'h00};

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read. Out-of-range
    // reads return a marker value the arbiter must never pass on.
    always @(posedge clk) begin
        if (rf_wr_en && (rf_rdwr_addr < 4'd8)) begin
            rfMem[rf_rdwr_addr[2:0]] <= rf_dat_in;
        end
    end

    assign rf_datA_out = (rf_rd_addr < 4'd8) ? rfMem[rf_rd_addr[2:0]] : 8'hEE;

    reg_file_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .lock         (lock),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .err          (err),
        .rf_wr_en     (rf_wr_en),
        .rf_rdwr_addr (rf_rdwr_addr),
        .rf_rd_addr   (rf_rd_addr),
        .rf_dat_in    (rf_dat_in),
        .rf_datA_out  (rf_datA_out)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic i, input txn_t t);
        req[i]  = 1'b1;
        we[i]   = t.we;
        lock[i] = t.lk;
        if (i) begin
            addr1  = t.addr;
            wdata1 = t.wdata;
        end else begin
            addr0  = t.addr;
            wdata0 = t.wdata;
        end
    endtask

    task automatic retire(input logic i);
        req[i]  = 1'b0;
        we[i]   = 1'b0;
        lock[i] = 1'b0;
    endtask

    function automatic logic [1:0] onehot(input logic o);
        return o ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] expRead(input logic [3:0] a);
        return (a < 4'd8) ? modelMem[a[2:0]] : 8'h00;
    endfunction

    function automatic void modelWrite(input logic [3:0] a, input logic [7:0] d);
        if (a < 4'd8) modelMem[a[2:0]] = d;
    endfunction

    function automatic txn_t mkTxn(input logic w, input logic [3:0] a, input logic [7:0] d, input logic l);
        txn_t t;
        t.we = w;
        t.addr = a;
        t.wdata = d;
        t.lk = l;
        return t;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        req = 2'b11;
        we = 2'b00;
        lock = 2'b00;
        addr0 = 4'd0;
        addr1 = 4'd1;
        wdata0 = 8'h00;
        wdata1 = 8'h00;
        for (int i = 0; i < 8; i++) modelMem[i] = 8'h00;
        lastModel = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({gnt, rvalid, rf_wr_en, rdata} !== 13'd0) begin
                failures++;
                $display("[TB] FAIL reset_outputs: gnt=%b rvalid=%b wr_en=%b rdata=%h, expected all zero", gnt, rvalid, rf_wr_en, rdata);
            end
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (gnt !== onehot(~lastModel)) begin
            failures++;
            $display("[TB] FAIL reset_first_gnt: got %b expected %b", gnt, onehot(~lastModel));
        end
        lastModel = 1'b0;
        retire(1'b0);
        tick();
        checks++;
        if (rvalid !== 2'b01 || rdata !== expRead(4'd0)) begin
            failures++;
            $display("[TB] FAIL reset_first_resp: rvalid=%b rdata=%h expected 01/%h", rvalid, rdata, expRead(4'd0));
        end
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_idle_bubble: gnt=%b expected 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_second_gnt: got %b expected 10", gnt);
        end
        lastModel = 1'b1;
        retire(1'b1);
        tick();
        checks++;
        if (rvalid !== 2'b10 || rdata !== expRead(4'd1)) begin
            failures++;
            $display("[TB] FAIL reset_second_resp: rvalid=%b rdata=%h expected 10/%h", rvalid, rdata, expRead(4'd1));
        end
        tick();
    endtask

    task automatic test_write_read();
        present(1'b0, mkTxn(1'b1, 4'd3, 8'hA5, 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b01 || err !== 2'b00 || rf_wr_en !== 1'b1 || rf_rdwr_addr !== 4'd3 || rf_dat_in !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL wr_access: gnt=%b err=%b wr_en=%b addr=%0d din=%h expected 01/00/1/3/a5", gnt, err, rf_wr_en, rf_rdwr_addr, rf_dat_in);
        end
        modelWrite(4'd3, 8'hA5);
        lastModel = 1'b0;
        present(1'b0, mkTxn(1'b0, 4'd3, 8'h00, 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b00 || rf_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_return_idle: gnt=%b wr_en=%b expected 00/0", gnt, rf_wr_en);
        end
        tick();
        checks++;
        if (gnt !== 2'b01 || rf_rd_addr !== 4'd3 || rf_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_access: gnt=%b rd_addr=%0d wr_en=%b expected 01/3/0", gnt, rf_rd_addr, rf_wr_en);
        end
        retire(1'b0);
        tick();
        checks++;
        if (rvalid !== 2'b01 || rdata !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL rd_resp: rvalid=%b rdata=%h expected 01/a5", rvalid, rdata);
        end
        tick();
        checks++;
        if (rvalid !== 2'b00 || rdata !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL rd_hold: rvalid=%b rdata=%h expected 00/a5", rvalid, rdata);
        end
    endtask

    task automatic test_random_traffic();
        txn_t q0[$];
        txn_t q1[$];
        txn_t t;
        logic expOwner;
        logic follow;
        logic prevOwner;
        logic [1:0] expErr;
        int toWait;
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mkTxn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 8'($urandom), ($urandom_range(0, 2) == 0)));
            q1.push_back(mkTxn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 8'($urandom), ($urandom_range(0, 2) == 0)));
        end
        present(1'b0, q0[0]);
        present(1'b1, q1[0]);
        toWait = 1;
        follow = 1'b0;
        prevOwner = 1'b0;
        for (int k = 0; k < 12; k++) begin
            repeat (toWait) tick();
            if (follow) expOwner = prevOwner;
            else if (q0.size() != 0 && q1.size() != 0) expOwner = ~lastModel;
            else expOwner = (q1.size() != 0);
            t = expOwner ? q1.pop_front() : q0.pop_front();
            expErr = (t.addr >= 4'd8) ? onehot(expOwner) : 2'b00;
            checks++;
            if (gnt !== onehot(expOwner) || err !== expErr) begin
                failures++;
                $display("[TB] FAIL rand_gnt[%0d]: gnt=%b err=%b expected %b/%b", k, gnt, err, onehot(expOwner), expErr);
            end
            checks++;
            if (rf_wr_en !== (t.we && (t.addr < 4'd8))) begin
                failures++;
                $display("[TB] FAIL rand_wr_en[%0d]: got %b expected %b", k, rf_wr_en, (t.we && (t.addr < 4'd8)));
            end
            lastModel = expOwner;
            prevOwner = expOwner;
            if (t.we) modelWrite(t.addr, t.wdata);
            if (expOwner) begin
                if (q1.size() != 0) present(1'b1, q1[0]);
                else retire(1'b1);
                follow = (q1.size() != 0) && q1[0].lk;
            end else begin
                if (q0.size() != 0) present(1'b0, q0[0]);
                else retire(1'b0);
                follow = (q0.size() != 0) && q0[0].lk;
            end
            if (!t.we) begin
                tick();
                checks++;
                if (rvalid !== onehot(expOwner) || rdata !== expRead(t.addr)) begin
                    failures++;
                    $display("[TB] FAIL rand_resp[%0d]: rvalid=%b rdata=%h expected %b/%h", k, rvalid, rdata, onehot(expOwner), expRead(t.addr));
                end
            end
            toWait = follow ? 1 : 2;
        end
        retire(1'b0);
        retire(1'b1);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rfMem[i] !== modelMem[i]) begin
                failures++;
                $display("[TB] FAIL rand_mem[%0d]: got %h expected %h", i, rfMem[i], modelMem[i]);
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] a0 [2];
        logic [3:0] a1 [2];
        logic [3:0] pa;
        logic [7:0] pd;
        logic [3:0] ra;
        logic expOwner;
        int n0 = 0;
        int n1 = 0;
        pa = 4'($urandom_range(0, 7));
        pd = 8'($urandom_range(1, 255));
        for (int i = 0; i < 2; i++) begin
            a0[i] = 4'($urandom_range(0, 7));
            a1[i] = 4'($urandom_range(0, 7));
        end
        a0[0] = pa;
        present(1'b1, mkTxn(1'b1, pa, pd, 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            failures++;
            $display("[TB] FAIL cont_prelude_gnt: got %b expected 10", gnt);
        end
        modelWrite(pa, pd);
        lastModel = 1'b1;
        retire(1'b1);
        tick();
        present(1'b0, mkTxn(1'b0, a0[0], 8'h00, 1'b0));
        present(1'b1, mkTxn(1'b0, a1[0], 8'h00, 1'b0));
        for (int k = 0; k < 4; k++) begin
            if (n0 < 2 && n1 < 2) expOwner = ~lastModel;
            else expOwner = (n1 < 2);
            tick();
            checks++;
            if (gnt !== onehot(expOwner)) begin
                failures++;
                $display("[TB] FAIL cont_gnt[%0d]: got %b expected %b", k, gnt, onehot(expOwner));
            end
            lastModel = expOwner;
            if (expOwner) begin
                ra = a1[n1];
                n1++;
                if (n1 < 2) present(1'b1, mkTxn(1'b0, a1[n1], 8'h00, 1'b0));
                else retire(1'b1);
            end else begin
                ra = a0[n0];
                n0++;
                if (n0 < 2) present(1'b0, mkTxn(1'b0, a0[n0], 8'h00, 1'b0));
                else retire(1'b0);
            end
            tick();
            checks++;
            if (rvalid !== onehot(expOwner) || rdata !== expRead(ra)) begin
                failures++;
                $display("[TB] FAIL cont_resp[%0d]: rvalid=%b rdata=%h expected %b/%h", k, rvalid, rdata, onehot(expOwner), expRead(ra));
            end
            tick();
            checks++;
            if (gnt !== 2'b00) begin
                failures++;
                $display("[TB] FAIL cont_bubble[%0d]: gnt=%b expected 00", k, gnt);
            end
        end
    endtask

    task automatic test_lock();
        txn_t w [4];
        for (int i = 0; i < 4; i++) begin
            w[i] = mkTxn(1'b1, 4'($urandom_range(0, 7)), 8'($urandom_range(1, 255)), 1'b1);
        end
        present(1'b1, w[0]);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (gnt !== 2'b10 || rf_wr_en !== 1'b1 || rf_rdwr_addr !== w[k].addr || rf_dat_in !== w[k].wdata) begin
                failures++;
                $display("[TB] FAIL lock_gnt[%0d]: gnt=%b wr_en=%b addr=%0d din=%h expected 10/1/%0d/%h", k, gnt, rf_wr_en, rf_rdwr_addr, rf_dat_in, w[k].addr, w[k].wdata);
            end
            modelWrite(w[k].addr, w[k].wdata);
            lastModel = 1'b1;
            if (k == 0) present(1'b0, mkTxn(1'b0, w[3].addr, 8'h00, 1'b0));
            if (k < 3) present(1'b1, w[k + 1]);
            else retire(1'b1);
        end
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            failures++;
            $display("[TB] FAIL lock_release_idle: gnt=%b expected 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("[TB] FAIL lock_then_gnt0: gnt=%b expected 01", gnt);
        end
        lastModel = 1'b0;
        retire(1'b0);
        tick();
        checks++;
        if (rvalid !== 2'b01 || rdata !== expRead(w[3].addr)) begin
            failures++;
            $display("[TB] FAIL lock_read_resp: rvalid=%b rdata=%h expected 01/%h", rvalid, rdata, expRead(w[3].addr));
        end
        tick();
    endtask

    task automatic test_range_error();
        int diffs = 0;
        present(1'b0, mkTxn(1'b1, 4'd9, 8'($urandom_range(1, 255)), 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b01 || err !== 2'b01 || rf_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_write: gnt=%b err=%b wr_en=%b expected 01/01/0", gnt, err, rf_wr_en);
        end
        lastModel = 1'b0;
        retire(1'b0);
        tick();
        checks++;
        if (err !== 2'b00) begin
            failures++;
            $display("[TB] FAIL err_clears: err=%b expected 00", err);
        end
        present(1'b0, mkTxn(1'b0, 4'd9, 8'h00, 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b01 || err !== 2'b01) begin
            failures++;
            $display("[TB] FAIL err_read: gnt=%b err=%b expected 01/01", gnt, err);
        end
        retire(1'b0);
        tick();
        checks++;
        if (rvalid !== 2'b01 || rdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL err_read_resp: rvalid=%b rdata=%h expected 01/00", rvalid, rdata);
        end
        for (int i = 0; i < 8; i++) if (rfMem[i] !== modelMem[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            failures++;
            $display("[TB] FAIL err_mem_intact: %0d entries differ, expected 0", diffs);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] r;
        int diffs = 0;
        r = 4'($urandom_range(0, 7));
        present(1'b0, mkTxn(1'b0, r, 8'h00, 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mid_gnt: got %b expected 01", gnt);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (rvalid !== 2'b00 || gnt !== 2'b00 || rdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL mid_reset_out: rvalid=%b gnt=%b rdata=%h expected 00/00/00", rvalid, gnt, rdata);
        end
        retire(1'b0);
        tick();
        checks++;
        if (rvalid !== 2'b00) begin
            failures++;
            $display("[TB] FAIL mid_no_rvalid: rvalid=%b expected 00", rvalid);
        end
        reset_n = 1'b1;
        lastModel = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || rf_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_idle: gnt=%b rvalid=%b wr_en=%b expected 00/00/0", gnt, rvalid, rf_wr_en);
        end
        for (int i = 0; i < 8; i++) if (rfMem[i] !== modelMem[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            failures++;
            $display("[TB] FAIL mid_mem_intact: %0d entries differ, expected 0", diffs);
        end
        present(1'b0, mkTxn(1'b0, r, 8'h00, 1'b0));
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mid_regrant: got %b expected 01", gnt);
        end
        retire(1'b0);
        tick();
        checks++;
        if (rvalid !== 2'b01 || rdata !== expRead(r)) begin
            failures++;
            $display("[TB] FAIL mid_reread: rvalid=%b rdata=%h expected 01/%h", rvalid, rdata, expRead(r));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_random_traffic();
        test_contention();
        test_lock();
        test_range_error();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
